cpu_ctrl_fsm_ws: RTL and testbench

//  Multi-cycle control FSM for the simple RISC CPU; next generation of the fetch/decode/execute controller.

---
 rtl/cpu_ctrl_fsm_ws.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm_ws.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm_ws.sv
// cpu_ctrl_fsm_ws: multi-cycle fetch/decode/execute controller for the simple
// RISC CPU, with a memory-ready handshake, bounded wait states, an ERROR trap
// and optional conditional branches.
//
// Ports:
//   clk, reset              clock / synchronous active-high reset (-> RST)
//   opcode, op, cond        IR[15:13], IR[12:11], IR[10:8]
//   Z, N, V                 status flags, used only in the BR state
//   mem_ready               memory finished current MREAD/MWRITE
//   reset_pc, load_pc, pc_sel, nsel, vsel, write, loada, loadb, asel, bsel,
//   loadc, loads, load_ir, addr_sel, load_addr, mem_cmd   datapath/memory controls
//   halted, error           state is HALT / ERROR (both sticky until reset)
module cpu_ctrl_fsm_ws #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4,
  parameter int BRANCH_EN  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       mem_ready,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       pc_sel,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       load_ir,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       error
);

  localparam logic [1:0] MREAD  = 2'b00;
  localparam logic [1:0] MNONE  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_MOV_IMM, S_GET_A, S_GET_B, S_ALU,
    S_ALU_B, S_WR_RD, S_ADDR, S_LADDR, S_MRD, S_MWB, S_STR_B, S_STR_C, S_MWR,
    S_BR, S_HALT, S_ERROR
  } state_t;

  // Instruction class latched at DEC so shared states (GET_A, GET_B, LADDR)
  // know where to go next without re-reading the IR fields.
  typedef enum logic [1:0] {K_ALU, K_ALU_B, K_LDR, K_STR} kind_t;

  typedef struct packed {
    logic       reset_pc, load_pc, pc_sel;
    logic [1:0] nsel, vsel;
    logic       write, loada, loadb, asel, bsel, loadc, loads;
    logic       load_ir, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted, error;
  } ctl_t;

  state_t           state, nxt;
  kind_t            kind, kind_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ctl_t             ctl_q;
  logic             taken;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    c.mem_cmd = MNONE;
    case (s)
      S_RST:     begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:     begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
      S_IF2:     begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
      S_UPC:     c.load_pc = 1'b1;
      S_MOV_IMM: begin c.nsel = 2'b11; c.vsel = 2'b11; c.write = 1'b1; end
      S_GET_A:   begin c.nsel = 2'b11; c.loada = 1'b1; end
      S_GET_B:   c.loadb = 1'b1;
      S_ALU:     begin c.loadc = 1'b1; c.loads = 1'b1; end
      S_ALU_B:   begin c.asel = 1'b1; c.loadc = 1'b1; c.loads = 1'b1; end
      S_WR_RD:   begin c.nsel = 2'b01; c.write = 1'b1; end
      S_ADDR:    begin c.bsel = 1'b1; c.loadc = 1'b1; c.loads = 1'b1; end
      S_LADDR:   c.load_addr = 1'b1;
      S_MRD:     c.mem_cmd = MREAD;
      S_MWB:     begin c.nsel = 2'b01; c.vsel = 2'b10; c.write = 1'b1; c.mem_cmd = MREAD; end
      S_STR_B:   begin c.nsel = 2'b01; c.loadb = 1'b1; end
      S_STR_C:   begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MWR:     c.mem_cmd = MWRITE;
      S_HALT:    c.halted = 1'b1;
      S_ERROR:   c.error = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

  always_comb begin
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = Z;
      3'b010:  taken = ~Z;
      3'b011:  taken = N ^ V;
      3'b100:  taken = (N ^ V) | Z;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt      = state;
    kind_nxt = kind;
    case (state)
      S_RST: nxt = S_IF1;
      // mem_ready wins over the timeout when both happen on the same cycle.
      S_IF1: if (mem_ready) nxt = S_IF2; else if (cnt == LIMIT) nxt = S_ERROR;
      S_IF2: nxt = S_UPC;
      S_UPC: nxt = S_DEC;
      S_DEC: begin
        nxt = S_RST;
        case (opcode)
          3'b110: if (op == 2'b10) nxt = S_MOV_IMM;
                  else if (op == 2'b00) begin nxt = S_GET_B; kind_nxt = K_ALU_B; end
          3'b101: if (op == 2'b11) begin nxt = S_GET_B; kind_nxt = K_ALU_B; end
                  else begin nxt = S_GET_A; kind_nxt = K_ALU; end
          3'b011: if (op == 2'b00) begin nxt = S_GET_A; kind_nxt = K_LDR; end
          3'b100: if (op == 2'b00) begin nxt = S_GET_A; kind_nxt = K_STR; end
          3'b001: if (BRANCH_EN != 0 && op == 2'b00) nxt = S_BR;
          3'b111: nxt = S_HALT;
          default: ;
        endcase
      end
      S_MOV_IMM: nxt = S_IF1;
      S_GET_A:   nxt = (kind == K_ALU) ? S_GET_B : S_ADDR;
      S_GET_B:   nxt = (kind == K_ALU) ? S_ALU : S_ALU_B;
      S_ALU:     nxt = S_WR_RD;
      S_ALU_B:   nxt = S_WR_RD;
      S_WR_RD:   nxt = S_IF1;
      S_ADDR:    nxt = S_LADDR;
      S_LADDR:   nxt = (kind == K_LDR) ? S_MRD : S_STR_B;
      S_MRD: if (mem_ready) nxt = S_MWB; else if (cnt == LIMIT) nxt = S_ERROR;
      S_MWB:     nxt = S_IF1;
      S_STR_B:   nxt = S_STR_C;
      S_STR_C:   nxt = S_MWR;
      S_MWR: if (mem_ready) nxt = S_IF1; else if (cnt == LIMIT) nxt = S_ERROR;
      S_BR:      nxt = S_IF1;
      S_HALT:    nxt = S_HALT;
      S_ERROR:   nxt = S_ERROR;
      default:   nxt = S_RST;
    endcase
  end

  // Counter runs only while sitting in a wait state; any entry clears it.
  always_comb begin
    cnt_nxt = '0;
    if (nxt == state && (state == S_IF1 || state == S_MRD || state == S_MWR))
      cnt_nxt = cnt + 1'b1;
  end

  // Outputs are registered from the next state so they line up with the
  // state register (Moore timing, no decode glitches).
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      kind  <= K_ALU;
      cnt   <= '0;
      ctl_q <= decode(S_RST);
    end else begin
      state <= nxt;
      kind  <= kind_nxt;
      cnt   <= cnt_nxt;
      ctl_q <= decode(nxt);
    end
  end

  // Branch decision uses the flags present during the BR cycle itself.
  logic br_take;
  assign br_take = (state == S_BR) && taken;

  assign reset_pc  = ctl_q.reset_pc;
  assign load_pc   = ctl_q.load_pc | br_take;
  assign pc_sel    = ctl_q.pc_sel | br_take;
  assign nsel      = ctl_q.nsel;
  assign vsel      = ctl_q.vsel;
  assign write     = ctl_q.write;
  assign loada     = ctl_q.loada;
  assign loadb     = ctl_q.loadb;
  assign asel      = ctl_q.asel;
  assign bsel      = ctl_q.bsel;
  assign loadc     = ctl_q.loadc;
  assign loads     = ctl_q.loads;
  assign load_ir   = ctl_q.load_ir;
  assign addr_sel  = ctl_q.addr_sel;
  assign load_addr = ctl_q.load_addr;
  assign mem_cmd   = ctl_q.mem_cmd;
  assign halted    = ctl_q.halted;
  assign error     = ctl_q.error;

endmodule

// File: tb/tb_cpu_ctrl_fsm_ws.sv
module tb_cpu_ctrl_fsm_ws;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] opcode = '0, cond = '0;
  logic [1:0] op = '0;
  logic Z = 1'b0, N = 1'b0, V = 1'b0, mem_ready = 1'b1;

  logic reset_pc, load_pc, pc_sel, write, loada, loadb, asel, bsel, loadc, loads;
  logic load_ir, addr_sel, load_addr, halted, error;
  logic [1:0] nsel, vsel, mem_cmd;
  logic nb_reset_pc, nb_load_pc, nb_pc_sel, nb_write, nb_loada, nb_loadb, nb_asel, nb_bsel;
  logic nb_loadc, nb_loads, nb_load_ir, nb_addr_sel, nb_load_addr, nb_halted, nb_error;
  logic [1:0] nb_nsel, nb_vsel, nb_mem_cmd;

  cpu_ctrl_fsm_ws dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond), .Z(Z), .N(N), .V(V),
    .mem_ready(mem_ready), .reset_pc(reset_pc), .load_pc(load_pc), .pc_sel(pc_sel),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb), .asel(asel),
    .bsel(bsel), .loadc(loadc), .loads(loads), .load_ir(load_ir), .addr_sel(addr_sel),
    .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted), .error(error));

  cpu_ctrl_fsm_ws #(.BRANCH_EN(0)) dut_nb (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond), .Z(Z), .N(N), .V(V),
    .mem_ready(mem_ready), .reset_pc(nb_reset_pc), .load_pc(nb_load_pc), .pc_sel(nb_pc_sel),
    .nsel(nb_nsel), .vsel(nb_vsel), .write(nb_write), .loada(nb_loada), .loadb(nb_loadb),
    .asel(nb_asel), .bsel(nb_bsel), .loadc(nb_loadc), .loads(nb_loads), .load_ir(nb_load_ir),
    .addr_sel(nb_addr_sel), .load_addr(nb_load_addr), .mem_cmd(nb_mem_cmd),
    .halted(nb_halted), .error(nb_error));

  logic [20:0] obs, obs_nb;
  assign obs = {reset_pc, load_pc, pc_sel, nsel, vsel, write, loada, loadb, asel, bsel,
                loadc, loads, load_ir, addr_sel, load_addr, mem_cmd, halted, error};
  assign obs_nb = {nb_reset_pc, nb_load_pc, nb_pc_sel, nb_nsel, nb_vsel, nb_write, nb_loada,
                   nb_loadb, nb_asel, nb_bsel, nb_loadc, nb_loads, nb_load_ir, nb_addr_sel,
                   nb_load_addr, nb_mem_cmd, nb_halted, nb_error};

  always #5 clk = ~clk;

  localparam int T_RST = 0, T_IF1 = 1, T_IF2 = 2, T_UPC = 3, T_DEC = 4, T_MOV = 5,
                 T_GA = 6, T_GB = 7, T_ALU = 8, T_ALUB = 9, T_WR = 10, T_ADDR = 11,
                 T_LADDR = 12, T_MRD = 13, T_MWB = 14, T_STRB = 15, T_STRC = 16,
                 T_MWR = 17, T_BR = 18, T_HALT = 19, T_ERR = 20;

  int checks = 0, errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] nb_q[$];
  bit          rdy_q[$];

  // Expected control word for a state, straight from the state/output table.
  function automatic logic [20:0] ev(input int st, input bit tk);
    logic r_pc, l_pc, p_sel, wr, la, lb, a_sel, b_sel, lc, ls, lir, adr, lad, h, er;
    logic [1:0] ns, vs, mc;
    {r_pc, l_pc, p_sel, wr, la, lb, a_sel, b_sel, lc, ls, lir, adr, lad, h, er} = '0;
    ns = 2'b00; vs = 2'b00; mc = 2'b01;
    case (st)
      T_RST:   begin r_pc = 1; l_pc = 1; end
      T_IF1:   begin adr = 1; mc = 2'b00; end
      T_IF2:   begin adr = 1; mc = 2'b00; lir = 1; end
      T_UPC:   l_pc = 1;
      T_MOV:   begin ns = 2'b11; vs = 2'b11; wr = 1; end
      T_GA:    begin ns = 2'b11; la = 1; end
      T_GB:    lb = 1;
      T_ALU:   begin lc = 1; ls = 1; end
      T_ALUB:  begin a_sel = 1; lc = 1; ls = 1; end
      T_WR:    begin ns = 2'b01; wr = 1; end
      T_ADDR:  begin b_sel = 1; lc = 1; ls = 1; end
      T_LADDR: lad = 1;
      T_MRD:   mc = 2'b00;
      T_MWB:   begin ns = 2'b01; vs = 2'b10; wr = 1; mc = 2'b00; end
      T_STRB:  begin ns = 2'b01; lb = 1; end
      T_STRC:  begin a_sel = 1; lc = 1; end
      T_MWR:   mc = 2'b10;
      T_BR:    if (tk) begin l_pc = 1; p_sel = 1; end
      T_HALT:  h = 1;
      T_ERR:   er = 1;
      default: ;
    endcase
    return {r_pc, l_pc, p_sel, ns, vs, wr, la, lb, a_sel, b_sel, lc, ls, lir, adr, lad, mc, h, er};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rdy is the mem_ready value presented at the edge that enters state st.
  task automatic push(input int st, input bit rdy, input bit tk);
    exp_q.push_back(ev(st, tk));
    rdy_q.push_back(rdy);
  endtask

  // IF2/UPC/DEC after IF1; mem_ready=0 while in UPC/DEC must be ignored.
  task automatic push_fetch();
    push(T_IF2, 1, 0); push(T_UPC, 0, 0); push(T_DEC, 0, 0);
  endtask

  task automatic start();
    reset = 1; mem_ready = 1;
    tick();
    reset = 0;
    exp_q.delete(); rdy_q.delete(); nb_q.delete();
  endtask

  task automatic test_reset();
    int k = 0;
    logic [20:0] e;
    reset = 1; mem_ready = 1; opcode = 3'b110; op = 2'b10;
    repeat (2) begin
      tick(); checks++;
      if (obs !== ev(T_RST, 0)) begin
        errors++; $display("FAIL reset_state: got %h expected %h", obs, ev(T_RST, 0));
      end
    end
    reset = 0;
    push(T_IF1, 1, 0); push(T_IF2, 1, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); mem_ready = rdy_q.pop_front(); tick(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_exit step %0d: got %h expected %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_mov();
    int k = 0;
    logic [20:0] e;
    opcode = 3'b110; op = 2'b10;
    start();
    push(T_IF1, 1, 0); push_fetch(); push(T_MOV, 0, 0); push(T_IF1, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); mem_ready = rdy_q.pop_front(); tick(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mov_imm cycle %0d: got %h expected %h", k + 1, obs, e); end
      k++;
    end
  endtask

  task automatic test_ldr_wait();
    int k = 0;
    logic [20:0] e;
    opcode = 3'b011; op = 2'b00;
    start();
    push(T_IF1, 1, 0); push_fetch();
    push(T_GA, 0, 0); push(T_ADDR, 0, 0); push(T_LADDR, 0, 0); push(T_MRD, 0, 0);
    repeat (3) push(T_MRD, 0, 0);
    push(T_MWB, 1, 0); push(T_IF1, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); mem_ready = rdy_q.pop_front(); tick(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ldr_wait step %0d: got %h expected %h", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_wait_limit();
    int k = 0;
    logic [20:0] e;
    opcode = 3'b110; op = 2'b10;
    for (int pass = 0; pass < 2; pass++) begin
      start();
      push(T_IF1, 0, 0);
      repeat (15) push(T_IF1, 0, 0);
      if (pass == 0) begin
        push(T_ERR, 0, 0);
        repeat (3) push(T_ERR, 1, 0);
      end else begin
        // Ready arriving on the limit cycle still advances normally.
        push(T_IF2, 1, 0); push(T_UPC, 1, 0);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); mem_ready = rdy_q.pop_front(); tick(); checks++;
        if (obs !== e) begin
          errors++; $display("FAIL wait_limit pass %0d step %0d: got %h expected %h", pass, k, obs, e);
        end
        k++;
      end
    end
  endtask

  task automatic test_branch();
    // {cond, Z, N, V, taken}
    logic [6:0] tbl [9] = '{7'b001_100_1, 7'b001_000_0, 7'b000_000_1, 7'b010_000_1,
                            7'b011_110_1, 7'b011_011_0, 7'b100_100_1, 7'b100_000_0,
                            7'b110_110_0};
    logic [20:0] e, enb;
    opcode = 3'b001; op = 2'b00;
    for (int i = 0; i < 9; i++) begin
      int k = 0;
      start();
      {cond, Z, N, V} = tbl[i][6:1];
      push(T_IF1, 1, 0); push_fetch(); push(T_BR, 1, tbl[i][0]); push(T_IF1, 1, 0);
      nb_q.push_back(ev(T_IF1, 0)); nb_q.push_back(ev(T_IF2, 0)); nb_q.push_back(ev(T_UPC, 0));
      nb_q.push_back(ev(T_DEC, 0)); nb_q.push_back(ev(T_RST, 0)); nb_q.push_back(ev(T_IF1, 0));
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); enb = nb_q.pop_front(); mem_ready = rdy_q.pop_front(); tick();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL branch case %0d step %0d: got %h expected %h", i, k, obs, e); end
        checks++;
        if (obs_nb !== enb) begin errors++; $display("FAIL branch_disabled case %0d step %0d: got %h expected %h", i, k, obs_nb, enb); end
        k++;
      end
    end
    Z = 0; N = 0; V = 0; cond = 0;
  endtask

  task automatic test_str_reset_halt();
    int k = 0;
    logic [20:0] e;
    opcode = 3'b100; op = 2'b00;
    start();
    push(T_IF1, 1, 0); push_fetch(); push(T_GA, 1, 0); push(T_ADDR, 1, 0); push(T_LADDR, 1, 0);
    push(T_STRB, 1, 0); push(T_STRC, 1, 0); push(T_MWR, 1, 0); push(T_MWR, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); mem_ready = rdy_q.pop_front(); tick(); checks++;
      if (obs !== e) begin errors++; $display("FAIL str step %0d: got %h expected %h", k, obs, e); end
      k++;
    end
    reset = 1; mem_ready = 0; tick(); reset = 0; checks++;
    if (obs !== ev(T_RST, 0)) begin errors++; $display("FAIL reset_mid_write: got %h expected %h", obs, ev(T_RST, 0)); end
    opcode = 3'b111; op = 2'b01;
    push(T_IF1, 1, 0); push_fetch(); push(T_HALT, 1, 0); push(T_HALT, 0, 0); push(T_HALT, 1, 0);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); mem_ready = rdy_q.pop_front(); tick(); checks++;
      if (obs !== e) begin errors++; $display("FAIL halt step %0d: got %h expected %h", k, obs, e); end
      k++;
    end
    reset = 1; tick(); reset = 0; checks++;
    if (obs !== ev(T_RST, 0)) begin errors++; $display("FAIL halt_exit: got %h expected %h", obs, ev(T_RST, 0)); end
  endtask

  task automatic test_back_to_back();
    logic [20:0] e;
    start();
    push(T_IF1, 1, 0);
    for (int s = 0; s < 7; s++) begin
      int k = 0;
      push_fetch();
      case (s)
        0: begin opcode = 3'b101; op = 2'b00;
             push(T_GA, 0, 0); push(T_GB, 0, 0); push(T_ALU, 0, 0); push(T_WR, 0, 0); push(T_IF1, 0, 0); end
        1: begin opcode = 3'b101; op = 2'b11;
             push(T_GB, 0, 0); push(T_ALUB, 0, 0); push(T_WR, 0, 0); push(T_IF1, 0, 0); end
        2: begin opcode = 3'b110; op = 2'b00;
             push(T_GB, 0, 0); push(T_ALUB, 0, 0); push(T_WR, 0, 0); push(T_IF1, 0, 0); end
        3: begin opcode = 3'b100; op = 2'b00;
             push(T_GA, 0, 0); push(T_ADDR, 0, 0); push(T_LADDR, 0, 0); push(T_STRB, 0, 0);
             push(T_STRC, 0, 0); push(T_MWR, 0, 0); push(T_IF1, 1, 0); end
        4: begin opcode = 3'b010; op = 2'b00; push(T_RST, 0, 0); push(T_IF1, 0, 0); end
        5: begin opcode = 3'b110; op = 2'b01; push(T_RST, 0, 0); push(T_IF1, 0, 0); end
        default: begin opcode = 3'b011; op = 2'b00;
             push(T_GA, 0, 0); push(T_ADDR, 0, 0); push(T_LADDR, 0, 0); push(T_MRD, 0, 0);
             repeat (15) push(T_MRD, 0, 0);
             push(T_ERR, 0, 0); push(T_ERR, 1, 0); end
      endcase
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); mem_ready = rdy_q.pop_front(); tick(); checks++;
        if (obs !== e) begin errors++; $display("FAIL back_to_back seg %0d step %0d: got %h expected %h", s, k, obs, e); end
        k++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mov();
    test_ldr_wait();
    test_wait_limit();
    test_branch();
    test_str_reset_halt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
